uart_tx_buffered: RTL
=====================

Name: uart_tx_buffered

Overview:
Transmit-side UART path for the core: the outbound counterpart of the receive FIFO that feeds the register file. The core pushes bytes from a UART-write instruction (WriteData[7:0]) into a small byte FIFO. A serializer drains the FIFO and drives an 8N1 frame on tx, LSB first. Status outputs let the control unit and software poll for space.

Parameters:
CLKS_PER_BIT, 10417, clk cycles per bit period (100 MHz / 9600 baud); legal range >= 2
DEPTH, 4, FIFO depth in bytes; must be a power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of the count output

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  one-cycle push strobe, decoded from UARTOp by the control unit
wr_data  input  8  byte to transmit (WriteData[7:0])
tx  output  1  serial line, idle high
busy  output  1  high while a frame is on the line (START/DATA/STOP/PARITY)
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  CNT_W  number of bytes queued, excluding the byte in the shifter
overflow  output  1  sticky: a push was dropped; cleared only by reset

Behaviour:
- Reset (synchronous, active-high): clk and reset are the only clock/reset. On the reset edge, with priority over every other input:
  - tx=1, busy=0, count=0, empty=1, full=0, overflow=0
  - FSM=IDLE; FIFO pointers, bit counter and baud counter are zeroed
  - a frame in progress is abandoned and tx returns high on that edge; a truncated frame is acceptable
- FIFO: circular buffer with wr_ptr/rd_ptr wrapping modulo DEPTH.
  - Push: on an edge with wr_en=1, the byte is written at wr_ptr if count<DEPTH or if a pop occurs on the same edge.
  - Dropped push: otherwise the byte is dropped and overflow is set to 1.
  - Simultaneous push and pop: count is unchanged.
  - full/empty/count: registered, and consistent with count on every cycle.
- Pop: occurs only on the FSM transition into START. The head byte loads into the 8-bit shift register and rd_ptr advances.
- FSM states IDLE, START, DATA, STOP (plus PARITY, see Optional Feature). The baud counter counts 0..CLKS_PER_BIT-1; a bit period ends at CLKS_PER_BIT-1.
  - IDLE: tx=1. If FIFO non-empty, go to START on the next edge and pop.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right one bit. After bit index 7, go to STOP (or PARITY if enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end of the period: if FIFO non-empty, go directly to START and pop (no idle cycle between frames); else go to IDLE.
- Latency: with wr_en sampled at edge E into an empty, idle block:
  - count=1 after edge E
  - FSM enters START and tx falls after edge E+1; count returns to 0 at the same edge
- Frame length: exactly 10*CLKS_PER_BIT cycles from tx falling to the end of the stop bit (11*CLKS_PER_BIT with parity).
- busy: high from the edge entering START until the edge leaving STOP to IDLE. Stays high across back-to-back frames.
- Outputs are registered; tx is glitch-free (driven from a flop).

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state sits between DATA and STOP and drives tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles. Frame is 8E1, 11 bit periods.
- Undefined: no PARITY state, frame is 8N1, 10 bit periods. All port lists and other timing are identical in both builds.

Test Plan:
- CLKS_PER_BIT=4, DEPTH=4. After reset, check tx=1, busy=0, empty=1, count=0, overflow=0. Push 0xA5 at edge E -> count=1 after E; tx falls after E+1; line carries 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each bit held 4 cycles; busy drops after cycle 40 of the frame.
- Push 0x00, 0xFF, 0x3C on three consecutive cycles -> three frames back-to-back with no idle cycle between a stop bit and the next start bit; count sequence 1,1,2 during pushes, then falls to 0 as frames start; busy stays high for 120 cycles.
- Fill the FIFO while the shifter is busy (5 pushes: 1 in shifter + 4 queued) -> full=1, count=4; a 6th push -> dropped, overflow=1, count stays 4. The byte sequence on tx matches the first 5 pushes only.
- With full=1, push on the exact edge where STOP ends and the next pop occurs -> push accepted, overflow stays 0, count stays 4.
- Assert reset for one cycle in the middle of DATA bit 3 of 0x81 with 2 bytes queued -> tx=1, busy=0, count=0 after that edge; no further frames.
- With UART_TX_PARITY_EN defined, push 0x07 -> parity bit 1 between bit 7 and stop, frame 44 cycles. Push 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - byte FIFO feeding an 8N1 UART serializer
// Define UART_TX_PARITY_EN for an even-parity bit between data and stop (8E1).
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DEPTH        = 4,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             tx,
    output logic             busy,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  L_DEPTH    = CNT_W'(DEPTH);
    localparam logic [BAUD_W-1:0] L_BAUD_END = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [7:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic              r_busy;
`ifdef UART_TX_PARITY_EN
    logic              r_parity;
`endif

    logic              w_baud_end;
    logic              w_pop;
    logic              w_push;
    logic [7:0]        w_head;
    logic [CNT_W-1:0]  w_count_next;

    assign w_baud_end = (r_baud == L_BAUD_END);
    assign w_head     = r_mem[r_rd_ptr];

    // A pop happens only when the FSM enters START, from IDLE or straight out of STOP.
    assign w_pop  = (r_count != '0) &&
                    ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_end));
    assign w_push = wr_en && ((r_count != L_DEPTH) || w_pop);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (wr_en && !w_push) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == L_DEPTH);
            r_empty <= (w_count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    r_tx   <= 1'b1;
                    if (w_pop) begin
                        r_state  <= S_START;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_head;
`endif
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        // Back-to-back frames: next start bit follows the stop bit directly.
                        if (w_pop) begin
                            r_state  <= S_START;
                            r_tx     <= 1'b0;
                            r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^w_head;
`endif
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_baud  <= '0;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
